// File: rtl/multicycle_control_if.sv
// ---------------------------------------------------------------------------
// multicycle_control_if
// Bundle of the IR fields, status flags and every control line exchanged
// between the multicycle MIPS control FSM and its datapath.
//   master : the control FSM (reads opcode/funct/flags, drives controls)
//   slave  : the datapath side (drives opcode/funct/flags, reads controls)
// ---------------------------------------------------------------------------
interface multicycle_control_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;

    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       instr_done;
    logic       illegal_op;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output iord, mem_read, mem_write, ir_write, pc_write, pc_source,
               alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg,
               reg_write, instr_done, illegal_op
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  iord, mem_read, mem_write, ir_write, pc_write, pc_source,
               alu_src_a, alu_src_b, alu_op, reg_dst, mem_to_reg,
               reg_write, instr_done, illegal_op
    );
endinterface

// File: rtl/multicycle_control.sv
// ---------------------------------------------------------------------------
// multicycle_control
// Main control FSM of the multicycle MIPS datapath. Sequences fetch, decode,
// execute, memory and writeback, and drives every datapath enable and mux
// select. Outputs are a Moore decode of the state register; the only
// current-cycle input terms are the mem_ready handshake and the ALU zero flag.
//
// alu_op: 00 add, 01 sub, 10 logical-immediate (AND), 11 R-type via funct.
//
// Optional build macro: MULTICYCLE_CTRL_PERF_COUNTERS_EN adds the
// cycle_count / instr_count performance counter outputs.
// ---------------------------------------------------------------------------
module multicycle_control #(
    parameter int          STATE_W = 4,
    parameter logic [1:0]  JAL_REG = 2'b10
) (
    input  logic                   clock,
    input  logic                   reset,
    multicycle_control_if.master   bus,
    output logic [STATE_W-1:0]     state
`ifdef MULTICYCLE_CTRL_PERF_COUNTERS_EN
    ,
    output logic [31:0]            cycle_count,
    output logic [31:0]            instr_count
`endif
);

    // ------------------------------------------------------------------
    // State encodings (all 16 codes of the 4-bit register are assigned)
    // ------------------------------------------------------------------
    localparam logic [STATE_W-1:0] S_RESET     = STATE_W'(4'd0);
    localparam logic [STATE_W-1:0] S_FETCH     = STATE_W'(4'd1);
    localparam logic [STATE_W-1:0] S_DECODE    = STATE_W'(4'd2);
    localparam logic [STATE_W-1:0] S_EXECUTE   = STATE_W'(4'd3);
    localparam logic [STATE_W-1:0] S_R_WB      = STATE_W'(4'd4);
    localparam logic [STATE_W-1:0] S_IMM_ADD   = STATE_W'(4'd5);
    localparam logic [STATE_W-1:0] S_IMM_AND   = STATE_W'(4'd6);
    localparam logic [STATE_W-1:0] S_IMM_WB    = STATE_W'(4'd7);
    localparam logic [STATE_W-1:0] S_MEM_ADDR  = STATE_W'(4'd8);
    localparam logic [STATE_W-1:0] S_MEM_READ  = STATE_W'(4'd9);
    localparam logic [STATE_W-1:0] S_MEM_WB    = STATE_W'(4'd10);
    localparam logic [STATE_W-1:0] S_MEM_WRITE = STATE_W'(4'd11);
    localparam logic [STATE_W-1:0] S_BRANCH    = STATE_W'(4'd12);
    localparam logic [STATE_W-1:0] S_JUMP      = STATE_W'(4'd13);
    localparam logic [STATE_W-1:0] S_JAL       = STATE_W'(4'd14);
    localparam logic [STATE_W-1:0] S_JR        = STATE_W'(4'd15);

    // ------------------------------------------------------------------
    // Opcode / funct values recognised by the decoder
    // ------------------------------------------------------------------
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    // Mux select codes
    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;
    localparam logic [1:0] PCS_REGA   = 2'b11;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_AND  = 2'b10;
    localparam logic [1:0] ALUOP_RTYP = 2'b11;

    localparam logic [1:0] RDST_RT    = 2'b00;
    localparam logic [1:0] RDST_RD    = 2'b01;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    // ------------------------------------------------------------------
    // State and internal signals
    // ------------------------------------------------------------------
    logic [STATE_W-1:0] state_q;
    logic [STATE_W-1:0] state_d;
    logic [STATE_W-1:0] decode_target_s;
    logic               decode_illegal_s;

    logic               iord_s;
    logic               mem_read_s;
    logic               mem_write_s;
    logic               ir_write_s;
    logic               pc_write_s;
    logic [1:0]         pc_source_s;
    logic               alu_src_a_s;
    logic [1:0]         alu_src_b_s;
    logic [1:0]         alu_op_s;
    logic [1:0]         reg_dst_s;
    logic [1:0]         mem_to_reg_s;
    logic               reg_write_s;
    logic               instr_done_s;
    logic               illegal_op_s;

    // Map the IR opcode/funct to the first post-decode state
    always_comb begin
        decode_target_s  = S_FETCH;
        decode_illegal_s = 1'b0;
        case (bus.opcode)
            OP_RTYPE: begin
                if (bus.funct == FN_JR) begin
                    decode_target_s = S_JR;
                end else begin
                    decode_target_s = S_EXECUTE;
                end
            end
            OP_LW, OP_SW:      decode_target_s = S_MEM_ADDR;
            OP_BEQ, OP_BNE:    decode_target_s = S_BRANCH;
            OP_J:              decode_target_s = S_JUMP;
            OP_JAL:            decode_target_s = S_JAL;
            OP_ADDI, OP_ADDIU: decode_target_s = S_IMM_ADD;
            OP_ANDI:           decode_target_s = S_IMM_AND;
            default: begin
                decode_target_s  = S_FETCH;
                decode_illegal_s = 1'b1;
            end
        endcase
    end

    // Next-state sequencing; memory states wait for the mem_ready handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:     state_d = S_FETCH;
            S_FETCH: begin
                if (bus.mem_ready) begin
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE:    state_d = decode_target_s;
            S_EXECUTE:   state_d = S_R_WB;
            S_R_WB:      state_d = S_FETCH;
            S_IMM_ADD:   state_d = S_IMM_WB;
            S_IMM_AND:   state_d = S_IMM_WB;
            S_IMM_WB:    state_d = S_FETCH;
            S_MEM_ADDR: begin
                if (bus.opcode == OP_LW) begin
                    state_d = S_MEM_READ;
                end else begin
                    state_d = S_MEM_WRITE;
                end
            end
            S_MEM_READ: begin
                if (bus.mem_ready) begin
                    state_d = S_MEM_WB;
                end else begin
                    state_d = S_MEM_READ;
                end
            end
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WRITE: begin
                if (bus.mem_ready) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_MEM_WRITE;
                end
            end
            S_BRANCH:    state_d = S_FETCH;
            S_JUMP:      state_d = S_FETCH;
            S_JAL:       state_d = S_FETCH;
            S_JR:        state_d = S_FETCH;
            default:     state_d = S_FETCH;
        endcase
    end

    // State register; reset abandons any in-flight instruction
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Control decode of the current state (zero/mem_ready are the only live inputs)
    always_comb begin
        iord_s       = 1'b0;
        mem_read_s   = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        pc_write_s   = 1'b0;
        pc_source_s  = PCS_ALU;
        alu_src_a_s  = 1'b0;
        alu_src_b_s  = SRCB_B;
        alu_op_s     = ALUOP_ADD;
        reg_dst_s    = RDST_RT;
        mem_to_reg_s = M2R_ALUOUT;
        reg_write_s  = 1'b0;
        instr_done_s = 1'b0;
        illegal_op_s = 1'b0;
        case (state_q)
            S_RESET: begin
                iord_s = 1'b0;
            end
            S_FETCH: begin
                // PC <= PC + 4 and IR load happen only when the read completes
                mem_read_s  = 1'b1;
                alu_src_b_s = SRCB_FOUR;
                ir_write_s  = bus.mem_ready;
                pc_write_s  = bus.mem_ready;
            end
            S_DECODE: begin
                // Branch target speculatively computed into ALUOut
                alu_src_b_s  = SRCB_IMMSH;
                illegal_op_s = decode_illegal_s;
                instr_done_s = decode_illegal_s;
            end
            S_EXECUTE: begin
                alu_src_a_s = 1'b1;
                alu_op_s    = ALUOP_RTYP;
            end
            S_R_WB: begin
                reg_dst_s    = RDST_RD;
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
            end
            S_IMM_ADD: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = SRCB_IMM;
            end
            S_IMM_AND: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = SRCB_IMM;
                alu_op_s    = ALUOP_AND;
            end
            S_IMM_WB: begin
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
            end
            S_MEM_ADDR: begin
                alu_src_a_s = 1'b1;
                alu_src_b_s = SRCB_IMM;
            end
            S_MEM_READ: begin
                mem_read_s = 1'b1;
                iord_s     = 1'b1;
            end
            S_MEM_WB: begin
                mem_to_reg_s = M2R_MDR;
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
            end
            S_MEM_WRITE: begin
                mem_write_s  = 1'b1;
                iord_s       = 1'b1;
                instr_done_s = bus.mem_ready;
            end
            S_BRANCH: begin
                // opcode[0] distinguishes BNE (1) from BEQ (0)
                alu_src_a_s  = 1'b1;
                alu_op_s     = ALUOP_SUB;
                pc_source_s  = PCS_ALUOUT;
                pc_write_s   = bus.opcode[0] ? ~bus.zero : bus.zero;
                instr_done_s = 1'b1;
            end
            S_JUMP: begin
                pc_source_s  = PCS_JUMP;
                pc_write_s   = 1'b1;
                instr_done_s = 1'b1;
            end
            S_JAL: begin
                // PC already holds PC+4 from FETCH, so it is the link value
                pc_source_s  = PCS_JUMP;
                pc_write_s   = 1'b1;
                reg_dst_s    = JAL_REG;
                mem_to_reg_s = M2R_PC;
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
            end
            S_JR: begin
                pc_source_s  = PCS_REGA;
                pc_write_s   = 1'b1;
                instr_done_s = 1'b1;
            end
            default: begin
                iord_s = 1'b0;
            end
        endcase
    end

    assign bus.iord       = iord_s;
    assign bus.mem_read   = mem_read_s;
    assign bus.mem_write  = mem_write_s;
    assign bus.ir_write   = ir_write_s;
    assign bus.pc_write   = pc_write_s;
    assign bus.pc_source  = pc_source_s;
    assign bus.alu_src_a  = alu_src_a_s;
    assign bus.alu_src_b  = alu_src_b_s;
    assign bus.alu_op     = alu_op_s;
    assign bus.reg_dst    = reg_dst_s;
    assign bus.mem_to_reg = mem_to_reg_s;
    assign bus.reg_write  = reg_write_s;
    assign bus.instr_done = instr_done_s;
    assign bus.illegal_op = illegal_op_s;
    assign state          = state_q;

`ifdef MULTICYCLE_CTRL_PERF_COUNTERS_EN
    logic [31:0] cycle_count_q;
    logic [31:0] instr_count_q;

    // Free-running cycle and retired-instruction counters, wrapping at 2^32
    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_count_q <= 32'd0;
            instr_count_q <= 32'd0;
        end else begin
            cycle_count_q <= cycle_count_q + 32'd1;
            if (instr_done_s) begin
                instr_count_q <= instr_count_q + 32'd1;
            end else begin
                instr_count_q <= instr_count_q;
            end
        end
    end

    assign cycle_count = cycle_count_q;
    assign instr_count = instr_count_q;
`endif

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Decodes the IR opcode/funct and sequences fetch, decode, execute, memory and writeback.
- Drives every datapath enable and mux select, plus the 2-bit alu_op consumed directly by the downstream ALU control block.
- Alu_op encoding: 00 add, 01 sub, 10 logical-immediate (AND), 11 R-type via funct.

Parameters:
- STATE_W, 4, width of state register and debug state port.
- JAL_REG, 2'b10, reg_dst code selecting register $31.

Ports:
- clock, input, 1, system clock, rising edge.
- reset, input, 1, synchronous active-high reset.
- opcode, input, 6, IR[31:26]; stable from DECODE to instruction end.
- funct, input, 6, IR[5:0].
- zero, input, 1, ALU zero flag (combinational, current cycle).
- mem_ready, input, 1, memory handshake; access completes in cycle where high.
- iord, output, 1, 0 = PC address, 1 = ALUOut address.
- mem_read, output, 1, memory read request.
- mem_write, output, 1, memory write request.
- ir_write, output, 1, load IR.
- pc_write, output, 1, final PC enable (branch condition already folded in).
- pc_source, output, 2, 00 ALU result, 01 ALUOut, 10 jump target, 11 register A.
- alu_src_a, output, 1, 0 = PC, 1 = A.
- alu_src_b, output, 2, 00 B, 01 const 4, 10 sign-extended imm, 11 imm<<2.
- alu_op, output, 2, operation class sent to ALU control.
- reg_dst, output, 2, 00 rt, 01 rd, 10 $31.
- mem_to_reg, output, 2, 00 ALUOut, 01 MDR, 10 PC.
- reg_write, output, 1, register file write enable.
- instr_done, output, 1, one-cycle pulse on the last cycle of each instruction.
- illegal_op, output, 1, one-cycle pulse in DECODE on an unsupported opcode/funct.
- state, output, STATE_W, current state (debug).

Behaviour:
- Reset:
  - reset=1 at a clock edge sets state to S_RESET regardless of current state; any in-flight instruction is abandoned.
  - In S_RESET all outputs are 0. The next cycle goes to FETCH.
- Outputs: Moore decode of the state register. The only Mealy terms are mem_ready gating and zero gating. Any output not listed for a state is 0.
- FETCH:
  - mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write=pc_write=mem_ready.
  - Holds while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_op=00 (branch target into ALUOut).
  - Next state by opcode:
    - 000000 goes to JR if funct=001000, else EXECUTE.
    - 100011/101011 go to MEM_ADDR.
    - 000100/000101 go to BRANCH.
    - 000010 goes to JUMP.
    - 000011 goes to JAL.
    - 001000/001001 go to IMM_ADD.
    - 001100 goes to IMM_AND.
    - Anything else: illegal_op=1, instr_done=1, next state FETCH.
- EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=11; next R_WB.
- R_WB: reg_dst=01, mem_to_reg=00, reg_write=1, instr_done=1; next FETCH.
- IMM_ADD: alu_src_a=1, alu_src_b=10, alu_op=00; next IMM_WB.
- IMM_AND: alu_src_a=1, alu_src_b=10, alu_op=10; next IMM_WB.
- IMM_WB: reg_dst=00, mem_to_reg=00, reg_write=1, instr_done=1; next FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; next MEM_READ for LW, MEM_WRITE for SW.
- MEM_READ: mem_read=1, iord=1; holds until mem_ready, then MEM_WB.
- MEM_WB: reg_dst=00, mem_to_reg=01, reg_write=1, instr_done=1; next FETCH.
- MEM_WRITE: mem_write=1, iord=1; holds until mem_ready, then instr_done=1 and next FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01.
  - pc_write = zero when opcode[0]=0 (BEQ), ~zero when opcode[0]=1 (BNE).
  - instr_done=1; next FETCH.
- JUMP: pc_source=10, pc_write=1, instr_done=1; next FETCH.
- JAL: pc_source=10, pc_write=1, reg_dst=10, mem_to_reg=10, reg_write=1, instr_done=1; next FETCH. The PC written to $31 is already PC+4.
- JR: pc_source=11, pc_write=1, instr_done=1; next FETCH.
- Latency with mem_ready tied high:
  - R-type, ADDI/ADDIU/ANDI, SW: 4 cycles.
  - LW: 5 cycles.
  - BEQ/BNE, J, JAL, JR: 3 cycles.
  - Each cycle with mem_ready=0 adds one cycle.
- Unused state encodings go to FETCH on the next cycle with all outputs 0.
- mem_read and mem_write are never high in the same cycle.

Optional Feature:
- Macro: MULTICYCLE_CTRL_PERF_COUNTERS_EN.
- When defined, adds two outputs:
  - cycle_count [31:0]: increments every non-reset cycle.
  - instr_count [31:0]: increments when instr_done=1.
  - Both clear on reset and wrap modulo 2^32.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset asserted in MEM_READ with mem_ready=0 -> next cycle state=S_RESET with all outputs 0, following cycle FETCH.
- R-type ADD (opcode 000000, funct 100000), mem_ready=1 -> sequence FETCH, DECODE, EXECUTE (alu_op=11), R_WB (reg_write=1, reg_dst=01); instr_done on cycle 4.
- LW (100011) with mem_ready low 2 cycles in MEM_READ -> MEM_READ held 3 cycles, iord=1; MEM_WB has mem_to_reg=01; total 7 cycles.
- BEQ (000100): zero=1 -> pc_write=1 in BRANCH; zero=0 -> pc_write=0. BNE (000101) gives the inverse. alu_op=01 in both cases.
- JAL (000011) -> cycle 3: pc_write=1, pc_source=10, reg_dst=10, mem_to_reg=10, reg_write=1; then FETCH.
- Opcode 111111 -> illegal_op and instr_done pulse in DECODE, next FETCH, no reg_write or mem_write at any point.
